// File: rtl/program_counter_if.sv
// Fetch-sequencer bus: control inputs toward the program counter and its status outputs.
// The master side drives the decoded instruction controls; the slave side is the sequencer.
interface program_counter_if #(
  parameter int W = 10,
  parameter int C = 16
) ();
  logic         Start;
  logic         Halt;
  logic         BranchEn;
  logic         Flag;
  logic [W-1:0] Target;
  logic [W-1:0] ProgCtr;
  logic         Running;
  logic         Done;
  logic [C-1:0] InstCount;

  modport master (
    output Start, Halt, BranchEn, Flag, Target,
    input  ProgCtr, Running, Done, InstCount
  );

  modport slave (
    input  Start, Halt, BranchEn, Flag, Target,
    output ProgCtr, Running, Done, InstCount
  );
endinterface

// File: rtl/program_counter.sv
// Instruction-fetch sequencer: steps or branches the PC once per cycle while running,
// frames execution with Start/Done, and keeps a saturating retired-instruction count.
module program_counter #(
  parameter int           W          = 10,
  parameter int           C          = 16,
  parameter logic [W-1:0] START_ADDR = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  program_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [C-1:0] cnt_q, cnt_d;
  logic [C-1:0] cnt_inc;

  // Count of retired instructions holds at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == {C{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a hold default first, so no branch
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (bus.Start) begin
          // Restart discards the instruction at the current PC without counting it.
          pc_d  = START_ADDR;
          cnt_d = '0;
        end else if (bus.Halt) begin
          state_d = HALTED;
          cnt_d   = cnt_inc;
        end else if (bus.BranchEn && bus.Flag) begin
          pc_d  = bus.Target;
          cnt_d = cnt_inc;
        end else begin
          pc_d  = pc_q + 1'b1;
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags decode straight from the state flops, so no input reaches an output.
  assign bus.ProgCtr   = pc_q;
  assign bus.InstCount = cnt_q;
  assign bus.Running   = (state_q == RUN);
  assign bus.Done      = (state_q == HALTED);

endmodule

// File: doc/program_counter.md
# program_counter

Instruction-fetch sequencer for the accumulator core. It owns the program counter, steps it once per cycle while a program runs, and loads the absolute branch target on a taken branch. The target comes from the jump-address ROM: the decoder drives the ROM's 4-bit location field from the instruction, and the ROM's 10-bit address output feeds `Target` here in the same cycle. The block also frames program execution with a Start/Done handshake and keeps an executed-instruction counter for the bench.

## Interface
- `W`, 10: program counter width; matches the jump-address ROM word width.
- `C`, 16: instruction counter width.
- `START_ADDR`, 0: PC value loaded on reset and on every Start.
- `Clk`  in  1  sole clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high.
- `Start`  in  1  sampled pulse; begins or restarts program execution.
- `Halt`  in  1  decoded halt instruction at current `ProgCtr`.
- `BranchEn`  in  1  decoded branch instruction at current `ProgCtr`.
- `Flag`  in  1  branch condition from ALU/accumulator; branch taken iff `BranchEn & Flag`.
- `Target`  in  W  absolute branch address from jump-address ROM, combinational in the same cycle.
- `ProgCtr`  out  W  registered address of the instruction currently executing.
- `Running`  out  1  high while in RUN.
- `Done`  out  1  registered; high from cycle after Halt until next Start or Reset.
- `InstCount`  out  C  count of instructions executed since last Start.

## Operation
- States: IDLE, RUN, HALTED. Encoding free; no other reachable states.
- Reset (async, any state, mid-program included):
  - state IDLE
  - `ProgCtr` = `START_ADDR`
  - `Done` = 0
  - `Running` = 0
  - `InstCount` = 0
- IDLE: all outputs held. `Start`=1 -> RUN, `ProgCtr`=`START_ADDR`, `InstCount`=0. `Halt`, `BranchEn` and `Flag` are ignored.
- RUN, one instruction retired per cycle. Priority, highest first:
  - `Start`=1: restart. `ProgCtr`=`START_ADDR`, `InstCount`=0, stay in RUN. The current instruction is not counted.
  - `Halt`=1: go to HALTED, `ProgCtr` held, `Done`=1 next cycle, `InstCount`+1.
  - `BranchEn & Flag`: `ProgCtr`=`Target`, `InstCount`+1.
  - Otherwise: `ProgCtr`=`ProgCtr`+1, `InstCount`+1.
- `BranchEn` with `Flag`=0 is a not-taken branch: behaves as the increment case.
- `Halt` and `BranchEn` both high: `Halt` wins.
- PC arithmetic is modulo 2^W: `ProgCtr` = 2^W-1 increments to 0 with no error indication.
- `Target` is used unmodified: no offset is added and no range check is applied.
- `InstCount` saturates at 2^C-1 and does not wrap.
- HALTED: `Done`=1; `ProgCtr` and `InstCount` are frozen. `Start`=1 -> RUN with `ProgCtr`=`START_ADDR`, `InstCount`=0, and `Done` drops the next cycle. `Halt` and `BranchEn` are ignored.
- `Running` = (state==RUN), registered.

## Timing
- Single-cycle fetch: `Target`, `Flag`, `Halt` and `BranchEn` are sampled at the edge ending the cycle in which `ProgCtr` shows the instruction. The new `ProgCtr` is visible one cycle later.
- `Start` sampled at edge k: `Running`=1, `ProgCtr`=`START_ADDR`, `Done`=0 after edge k.
- `Halt` sampled at edge k: `Done`=1, `Running`=0 after edge k. `Done` remains high until the edge that samples `Start`, or until Reset.
- No combinational path from any input to any output.
- Reset deassertion is assumed synchronous to `Clk` at system level. The first active edge after deassertion is a normal IDLE cycle.

## Test plan
- Reset then Start with no branches for 5 cycles -> `ProgCtr` 0,1,2,3,4,5; `InstCount`=5; `Running`=1; `Done`=0.
- In RUN at PC=3: `BranchEn`=1, `Flag`=1, `Target`=10'h2A -> next `ProgCtr`=42. Repeat with `Flag`=0 -> `ProgCtr`=4.
- At PC=7: `Halt`=1 together with a taken branch -> `Done`=1, `Running`=0, `ProgCtr` stays 7. Next `Start` -> `ProgCtr`=0, `InstCount`=0, `Done`=0 one cycle later.
- Force `ProgCtr` to 1023 via a taken branch to 10'h3FF, then run one plain cycle -> `ProgCtr`=0 and `InstCount` keeps counting.
- Assert Reset asynchronously mid-RUN at PC=9, between clock edges -> outputs go to reset values immediately; after release the block stays in IDLE until `Start`.
- Set `C`=4 and run 20 instructions -> `InstCount` saturates at 15. A `Start` pulse in mid-RUN -> `ProgCtr`=0 and the count clears.
